// File: rtl/nonres_pkg.sv
// Shared widths and result record for the non-restoring divider fix-up stage.
package nonres_pkg;

  localparam int DW   = 2;
  localparam int QW   = 3;
  localparam int RW   = 5;
  localparam int CNTW = 8;

  typedef struct packed {
    logic [QW-1:0] quo;
    logic [DW-1:0] rem;
    logic          dz;
  } result_t;

endpackage

// File: rtl/nonres_fix_comb.sv
// Combinational quotient/remainder correction for a raw non-restoring result.
module nonres_fix_comb
  import nonres_pkg::*;
(
  input  logic        [DW-1:0] d,
  input  logic        [QW-1:0] q,
  input  logic signed [RW-1:0] r_n1,
  output result_t              res,
  output logic                 corr
);

  logic signed [RW-1:0] sum;

  // D is zero-extended so the add stays a plain two's-complement 5-bit sum
  assign sum = r_n1 + $signed({{(RW-DW){1'b0}}, d});

  always_comb begin
    res  = '0;
    corr = 1'b0;
    if (d == '0) begin
      res.quo = '1;
      res.rem = '0;
      res.dz  = 1'b1;
    end else if (r_n1[RW-1]) begin
      res.quo = q - QW'(1);
      res.rem = sum[DW-1:0];
      corr    = 1'b1;
    end else begin
      res.quo = q;
      res.rem = r_n1[DW-1:0];
    end
  end

endmodule

// File: rtl/nonres_fixup.sv
// Two-stage valid/ready pipeline that applies the final non-restoring
// correction step and counts how many emitted results needed it.
module nonres_fixup
  import nonres_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   D,
  input  logic [QW-1:0]   Q,
  input  logic [RW-1:0]   R_n1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [QW-1:0]   quo,
  output logic [DW-1:0]   rem,
  output logic            dz,
  output logic [CNTW-1:0] corr_cnt
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == '1) ? v : v + CNTW'(1);
  endfunction

  logic                 vld_p1, vld_p2;
  logic        [DW-1:0] d_p1;
  logic        [QW-1:0] q_p1;
  logic signed [RW-1:0] r_p1;
  result_t              res_c, res_p2;
  logic                 corr_c, corr_p2;
  logic      [CNTW-1:0] cnt;
  logic                 take, adv;

  assign in_ready = !rst && (!vld_p1 || !vld_p2 || out_ready);
  assign take     = in_valid && in_ready;
  assign adv      = vld_p1 && (!vld_p2 || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      cnt    <= '0;
    end else begin
      vld_p1 <= take || (vld_p1 && !adv);
      vld_p2 <= adv || (vld_p2 && !out_ready);
      if (vld_p2 && out_ready && corr_p2)
        cnt <= sat_inc(cnt);
    end
  end

  // S1: raw tuple capture
  always_ff @(posedge clk) begin
    if (take) begin
      d_p1 <= D;
      q_p1 <= Q;
      r_p1 <= $signed(R_n1);
    end
  end

  nonres_fix_comb u_fix (
    .d    (d_p1),
    .q    (q_p1),
    .r_n1 (r_p1),
    .res  (res_c),
    .corr (corr_c)
  );

  // S2: corrected result, held while downstream stalls
  always_ff @(posedge clk) begin
    if (adv) begin
      res_p2  <= res_c;
      corr_p2 <= corr_c;
    end
  end

  assign out_valid = vld_p2 && !rst;
  assign quo       = rst ? '0 : res_p2.quo;
  assign rem       = rst ? '0 : res_p2.rem;
  assign dz        = rst ? 1'b0 : res_p2.dz;
  assign corr_cnt  = cnt;

endmodule

// File: tb/tb_nonres_fixup.sv
// Table-driven, scoreboarded bench for nonres_fixup.
module tb_nonres_fixup;
  import nonres_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] D = '0;
  logic [2:0] Q = '0;
  logic [4:0] R_n1 = '0;
  logic       in_ready, out_valid, dz;
  logic [2:0] quo;
  logic [1:0] rem;
  logic [7:0] corr_cnt;

  nonres_fixup dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .D(D), .Q(Q), .R_n1(R_n1), .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .rem(rem), .dz(dz), .corr_cnt(corr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] d;
    logic [2:0] q;
    logic [4:0] r;
    logic [2:0] eq;
    logic [1:0] er;
    logic       edz;
    logic       ecorr;
  } vec_t;

  typedef struct {
    logic [2:0] quo;
    logic [1:0] rem;
    logic       dz;
    logic       corr;
  } exp_t;

  vec_t vt [10];
  exp_t sb [$];
  exp_t cur_exp;
  int   nvec = 0;
  int   nerr = 0;
  int   model_cnt = 0;
  bit   busy;

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [1:0] d, input logic [2:0] q, input logic [4:0] r);
    exp_t e;
    int rs;
    rs = (r >= 5'd16) ? int'(r) - 32 : int'(r);
    if (d == 2'd0) begin
      e.quo = 3'd7; e.rem = 2'd0; e.dz = 1'b1; e.corr = 1'b0;
    end else if (rs < 0) begin
      e.quo = 3'((int'(q) + 7) % 8);
      e.rem = 2'((rs + int'(d)) & 3);
      e.dz = 1'b0; e.corr = 1'b1;
    end else begin
      e.quo = q; e.rem = 2'(rs & 3); e.dz = 1'b0; e.corr = 1'b0;
    end
    return e;
  endfunction

  task automatic send(input logic [1:0] d, input logic [2:0] q, input logic [4:0] r, input exp_t e);
    bit hs;
    bit done;
    done = 1'b0;
    in_valid = 1'b1; D = d; Q = q; R_n1 = r; cur_exp = e;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) done = 1'b1;
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_vec(input vec_t v);
    exp_t e;
    e.quo = v.eq; e.rem = v.er; e.dz = v.edz; e.corr = v.ecorr;
    send(v.d, v.q, v.r, e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("stale_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("quo", quo, e.quo);
          chk("rem", rem, e.rem);
          chk("dz", dz, e.dz);
          chk("corr_cnt", corr_cnt, model_cnt);
          if (e.corr && model_cnt < 255) model_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t snap;
    exp_t e;
    time  t0;

    vt[0] = '{2'd2, 3'd3, 5'b11111, 3'd2, 2'd1, 1'b0, 1'b1};
    vt[1] = '{2'd3, 3'd2, 5'b00001, 3'd2, 2'd1, 1'b0, 1'b0};
    vt[2] = '{2'd0, 3'd5, 5'b00110, 3'd7, 2'd0, 1'b1, 1'b0};
    vt[3] = '{2'd3, 3'd0, 5'b11110, 3'd7, 2'd1, 1'b0, 1'b1};
    vt[4] = '{2'd1, 3'd4, 5'b00000, 3'd4, 2'd0, 1'b0, 1'b0};
    vt[5] = '{2'd3, 3'd7, 5'b11101, 3'd6, 2'd0, 1'b0, 1'b1};
    vt[6] = '{2'd2, 3'd1, 5'b00001, 3'd1, 2'd1, 1'b0, 1'b0};
    vt[7] = '{2'd0, 3'd0, 5'b11111, 3'd7, 2'd0, 1'b1, 1'b0};
    vt[8] = '{2'd3, 3'd5, 5'b00010, 3'd5, 2'd2, 1'b0, 1'b0};
    vt[9] = '{2'd1, 3'd1, 5'b11111, 3'd0, 2'd0, 1'b0, 1'b1};

    // reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_quo", quo, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dz", dz, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_corr_cnt", corr_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single correcting tuple: two-cycle latency, counter 0 -> 1
    out_ready = 1'b1;
    send_vec(vt[0]);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_out_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_out_valid", out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cnt_after_first", corr_cnt, 1);

    // table streamed back to back
    for (int i = 1; i < 10; i++) send_vec(vt[i]);
    in_valid = 1'b0;
    drain();
    chk("cnt_after_table", corr_cnt, 4);

    // table again under random downstream stalls
    busy = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send_vec(vt[i]);
        in_valid = 1'b0;
        busy = 1'b0;
      end
      begin
        while (busy) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("cnt_after_random", corr_cnt, 8);

    // backpressure: 4 back-to-back tuples, downstream stalled 5 cycles
    out_ready = 1'b0;
    fork
      begin
        send(2'd3, 3'd1, 5'b11110, model(2'd3, 3'd1, 5'b11110));
        send(2'd2, 3'd6, 5'b00001, model(2'd2, 3'd6, 5'b00001));
        send(2'd1, 3'd3, 5'b11111, model(2'd1, 3'd3, 5'b11111));
        send(2'd3, 3'd4, 5'b00010, model(2'd3, 3'd4, 5'b00010));
        in_valid = 1'b0;
      end
      begin
        for (int i = 1; i <= 5; i++) begin
          @(negedge clk);
          if (i >= 3) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            if (i == 3) begin
              snap.quo = quo; snap.rem = rem; snap.dz = dz;
            end else begin
              chk("bp_quo_stable", quo, snap.quo);
              chk("bp_rem_stable", rem, snap.rem);
              chk("bp_dz_stable", dz, snap.dz);
            end
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("cnt_after_bp", corr_cnt, 10);

    // reset with both stages full
    out_ready = 1'b0;
    send(2'd2, 3'd3, 5'b11111, model(2'd2, 3'd3, 5'b11111));
    send(2'd3, 3'd0, 5'b11110, model(2'd3, 3'd0, 5'b11110));
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_quo", quo, 0);
    chk("midrst_rem", rem, 0);
    chk("midrst_dz", dz, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    t0 = $time;
    e = model(2'd3, 3'd2, 5'b00001);
    send(2'd3, 3'd2, 5'b00001, e);
    chk("accept_after_rst_ns", int'($time - t0), 10);
    in_valid = 1'b0;
    drain();
    chk("cnt_after_midrst", corr_cnt, 0);

    // saturation of the correction counter
    for (int i = 0; i < 260; i++) begin
      send(2'd1, 3'(i % 8), 5'b11111, model(2'd1, 3'(i % 8), 5'b11111));
    end
    in_valid = 1'b0;
    drain();
    chk("cnt_saturated", corr_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/nonres_fixup.md
NONRES_FIXUP -- requirements
Module: nonres_fixup

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream tuple valid.
REQ-005 SHALL have port: in_ready  output  1  tuple accepted when in_valid && in_ready at clk edge.
REQ-006 SHALL have port: D  input  2  divisor, unsigned.
REQ-007 SHALL have port: Q  input  3  raw non-restoring quotient from the divider stage.
REQ-008 SHALL have port: R_n1  input  5  raw remainder, two's complement.
REQ-009 SHALL have port: out_valid  output  1  corrected result valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-011 SHALL have port: quo  output  3  corrected quotient.
REQ-012 SHALL have port: rem  output  2  corrected remainder, unsigned, 0 <= rem < D.
REQ-013 SHALL have port: dz  output  1  divide-by-zero flag, qualified by out_valid.
REQ-014 SHALL have port: corr_cnt  output  8  saturating count of emitted corrected results.

Function
REQ-015 SHALL implement a 2-stage pipeline: S1 captures {D,Q,R_n1}; S2 holds the corrected {quo,rem,dz}.
REQ-016 SHALL present out_valid exactly 2 cycles after acceptance when out_ready is held high (throughput 1 tuple/cycle).
REQ-017 SHALL drive in_ready = !S1_valid || !S2_valid || out_ready, combinationally.
REQ-018 SHALL advance S1 into S2 when S1_valid && (!S2_valid || out_ready).
REQ-019 SHALL, with D==0, produce dz=1, quo=3'b111, rem=2'b00, with no correction applied.
REQ-020 SHALL, with D!=0 and R_n1[4]==1, produce rem=(R_n1+D)[1:0] and quo=(Q-1) mod 8 (correction).
REQ-021 SHALL, with D!=0 and R_n1[4]==0, produce rem=R_n1[1:0] and quo=Q unchanged.
REQ-022 SHALL compute correction arithmetic at 5-bit width with D zero-extended.
REQ-023 SHALL hold S2 contents and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL, when S2 empties and S1 refills in the same cycle, sustain the pipeline with no bubble and no lost or duplicated tuple.
REQ-025 SHALL increment corr_cnt by 1 on each output handshake of a tuple that took the REQ-020 path, saturating at 255.
REQ-026 SHALL leave the out-of-contract case (R_n1+D still negative) undefined in rem, with no flag.

Reset
REQ-027 SHALL clear S1_valid, S2_valid, out_valid, and corr_cnt to 0 on rst.
REQ-028 SHALL drive quo, rem, and dz to 0 while in reset.
REQ-029 SHALL discard in-flight tuples on rst asserted mid-operation.
REQ-030 SHALL hold in_ready at 0 during the rst cycle.
REQ-031 SHALL accept input from the first cycle after rst deasserts.

Structure
REQ-032 SHALL place widths (DW=2, QW=3, RW=5, CNTW=8) and the result struct {quo,rem,dz} in shared package nonres_pkg.
REQ-033 SHALL implement the correction in one combinational sub-module, nonres_fix_comb, between S1 and S2.
REQ-034 SHALL contain no latches and a single clock domain.

Verification
REQ-035 SHALL cover the correction path: D=2, Q=3, R_n1=5'b11111 -> quo=2, rem=1, dz=0, corr_cnt 0->1.
REQ-036 SHALL cover the no-correction path: D=3, Q=2, R_n1=5'b00001 -> quo=2, rem=1, dz=0, corr_cnt unchanged.
REQ-037 SHALL cover divide-by-zero: D=0, Q=5, R_n1=5'b00110 -> dz=1, quo=7, rem=0.
REQ-038 SHALL cover backpressure: 4 back-to-back tuples with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted, outputs stable, all 4 delivered in order after release.
REQ-039 SHALL cover reset mid-stream: rst with S1 and S2 both full -> next cycle out_valid=0, corr_cnt=0, no stale tuple emitted.
REQ-040 SHALL cover saturation: 260 correcting tuples -> corr_cnt=255.
